spi_flash_target: RTL and testbench
===================================

SPI_FLASH_TARGET -- requirements
Module: spi_flash_target

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 1024, meaning the number of 32-bit backing words; it must be a power of two ≥ 4.
REQ-002 SHALL have parameter JEDEC_ID, default 24'hEF4016, meaning the 3-byte ID returned by opcode 0x9F.
REQ-003 SHALL have port sft_clock_i, input, 1 bit: the single clock. sck, mosi and cs_n are synchronous to this clock.
REQ-004 SHALL have port sft_reset_i, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port sck, input, 1 bit: SPI clock, mode 3 (idles high), toggling at most once per clock.
REQ-006 SHALL have port mosi, input, 1 bit: controller-to-target data, MSB first.
REQ-007 SHALL have port cs_n, input, 1 bit: active-low chip select.
REQ-008 SHALL have port miso, output, 1 bit: target-to-controller data, MSB first.
REQ-009 SHALL have port init_wen, input, 1 bit: backdoor word-write strobe.
REQ-010 SHALL have port init_addr, input, $clog2(MEM_WORDS) bits: backdoor word index.
REQ-011 SHALL have port init_data, input, 32 bits: backdoor write data.
REQ-012 SHALL have port wel_o, output, 1 bit: current write-enable-latch state.

Function
REQ-013 SHALL detect sck edges by comparing sck to a registered copy: rise = sck & ~prev, fall = ~sck & prev.
REQ-014 SHALL sample mosi on every detected rise while cs_n=0.
REQ-015 SHALL update miso only in the cycle after a detected fall, so miso is stable throughout the sck-high phase.
REQ-016 SHALL implement the following states:
- IDLE
- OPCODE (8 bits)
- ADDR (24 bits)
- READ_OUT
- STATUS_OUT
- ID_OUT
- PROG_IN
- IGNORE
REQ-017 SHALL enter OPCODE on cs_n falling.
REQ-018 SHALL return to IDLE from any state within 1 cycle of cs_n=1, discarding partial bits and driving miso 0.
REQ-019 Opcode dispatch after the 8th bit SHALL be: 0x03→ADDR then READ_OUT; 0x05→STATUS_OUT; 0x9F→ID_OUT; 0x06/0x04/0x02 per REQ-029 to REQ-031; any other opcode→IGNORE until cs_n=1.
REQ-020 Byte address mapping SHALL be word = A[$clog2(MEM_WORDS)+1:2] and lane = A[1:0]; lane 0 = data[31:24]; upper address bits are ignored (aliasing).
REQ-021 READ_OUT SHALL need zero dummy cycles: the first data bit (MSB of byte at A) is on miso before the first sck rise following the address LSB rise.
REQ-022 READ_OUT SHALL stream bytes continuously, incrementing the address after each byte and wrapping modulo 4*MEM_WORDS, until cs_n=1.
REQ-023 A 4-byte read at an aligned address SHALL return the stored word MSB-first, i.e. the controller assembles the identical 32-bit value.
REQ-024 STATUS_OUT SHALL repeat the byte {6'b0, WEL, 1'b0} (WIP always 0) until cs_n=1.
REQ-025 ID_OUT SHALL emit JEDEC_ID[23:16], [15:8], [7:0], then 0x00 repeatedly.
REQ-026 The backing memory SHALL be a read-1-cycle array.
REQ-027 The backing memory contents SHALL be unaffected by reset and initialised to 0xFFFFFFFF.
REQ-028 init_wen SHALL write init_data at init_addr in the same clock; when it coincides with a program write to the same word, init SHALL win.

Configuration
REQ-029 With SFT_PROGRAM_EN defined: 0x06 SHALL set WEL and 0x04 SHALL clear WEL, both taking effect at cs_n rise after exactly 8 bits.
REQ-030 With SFT_PROGRAM_EN defined: 0x02 with WEL=1 SHALL take a 24-bit address, then each completed byte SHALL update the addressed byte as old & new (bits only clear).
REQ-031 With SFT_PROGRAM_EN defined: during 0x02, the address SHALL increment within a 256-byte page (A[7:0] wraps, A[23:8] fixed); WEL SHALL clear at cs_n rise; a partial trailing byte SHALL be discarded; 0x02 with WEL=0 SHALL go to IGNORE.
REQ-032 Without SFT_PROGRAM_EN: 0x06, 0x04 and 0x02 SHALL go to IGNORE, and wel_o SHALL be constant 0.

Reset
REQ-033 Reset SHALL set state=IDLE, miso=0, WEL=0, wel_o=0, bit/byte counters=0 and address=0.
REQ-034 Reset asserted mid-transfer SHALL abort the transfer; the target SHALL then wait for a fresh cs_n fall and ignore bits until then.

Verification
REQ-035 init word 4 = 0x12345678; READ 0x03 addr 0x000010, 32 bits (sck toggling every clock) → controller receives 0x12345678.
REQ-036 init words 4/5 = 0x12345678/0x9ABCDEF0; READ addr 0x000013, 16 bits → 0x78, 0x9A; READ at 4*MEM_WORDS-1 for 2 bytes → last byte then byte 0.
REQ-037 Opcode 0x9F, 32 bits → 0xEF401600.
REQ-038 cs_n raised after 12 address bits, then full READ of addr 0x000010 → 0x12345678 (no residue).
REQ-039 SFT_PROGRAM_EN: 0x06; 0x02 addr 0x000000 data 0x0F; READ 4 bytes → 0x0FFFFFFF and status byte 0x00; repeating 0x02 without 0x06 → word unchanged.
REQ-040 Reset pulsed during READ_OUT → miso=0 next cycle; wel_o=0; the following READ returns correct data.

Source files
------------

// File: rtl/spi_flash_target.sv
// rtl/spi_flash_target.sv - SPI NOR flash target (mode 3) with word-wide backing memory
//
// Purpose: behaves as a small serial NOR flash on an oversampled SPI bus.
//   Supported opcodes: 0x03 READ, 0x05 READ STATUS, 0x9F READ JEDEC ID.
//   Optional macro SFT_PROGRAM_EN adds 0x06 WREN, 0x04 WRDI, 0x02 PAGE PROGRAM.
//   Without the macro those three opcodes are ignored and wel_o is tied low.
// Ports:
//   sft_clock_i  system clock; sck/mosi/cs_n are synchronous to it
//   sft_reset_i  synchronous active-high reset
//   sck          SPI clock (idles high), at most one toggle per sft_clock_i
//   mosi         controller-to-target data, MSB first, sampled on sck rise
//   cs_n         active-low chip select
//   miso         target-to-controller data, MSB first, changes after sck fall
//   init_wen     backdoor word-write strobe
//   init_addr    backdoor word index
//   init_data    backdoor write data
//   wel_o        write-enable latch
module spi_flash_target #(
  parameter int          MEM_WORDS = 1024,
  parameter logic [23:0] JEDEC_ID  = 24'hEF4016
) (
  input  logic                         sft_clock_i,
  input  logic                         sft_reset_i,
  input  logic                         sck,
  input  logic                         mosi,
  input  logic                         cs_n,
  output logic                         miso,
  input  logic                         init_wen,
  input  logic [$clog2(MEM_WORDS)-1:0] init_addr,
  input  logic [31:0]                  init_data,
  output logic                         wel_o
);

  localparam int AW = $clog2(MEM_WORDS);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_OPCODE = 3'd1;
  localparam logic [2:0] S_ADDR   = 3'd2;
  localparam logic [2:0] S_READ   = 3'd3;
  localparam logic [2:0] S_STATUS = 3'd4;
  localparam logic [2:0] S_ID     = 3'd5;
  localparam logic [2:0] S_PROG   = 3'd6;
  localparam logic [2:0] S_IGNORE = 3'd7;

  logic [31:0] r_mem [MEM_WORDS] = '{default: 32'hFFFF_FFFF};

  logic        r_sck_prev;
  logic        r_cs_prev;
  logic [2:0]  r_state;
  logic [4:0]  r_bit_cnt;
  logic [1:0]  r_byte_cnt;
  logic [6:0]  r_shift_in;
  logic [7:0]  r_tx;
  logic [23:0] r_addr;
  logic [31:0] r_rdata;
  logic        r_is_prog;
  logic        r_miso;

  logic          w_rise;
  logic          w_fall;
  logic          w_cs_fall;
  logic [7:0]    w_byte_in;
  logic [23:0]   w_addr_in;
  logic [AW-1:0] w_rd_word;
  logic [7:0]    w_lane_byte;
  logic [7:0]    w_out_byte;
  logic          w_wel;

  assign w_rise    = sck & ~r_sck_prev;
  assign w_fall    = ~sck & r_sck_prev;
  assign w_cs_fall = ~cs_n & r_cs_prev;
  assign w_byte_in = {r_shift_in, mosi};
  assign w_addr_in = {r_addr[22:0], mosi};

  // While the address is still arriving, look up the word the address will
  // have after this bit, so the first read byte is ready on the very next fall.
  assign w_rd_word = (r_state == S_ADDR) ? w_addr_in[AW+1:2] : r_addr[AW+1:2];

  always_ff @(posedge sft_clock_i) begin
    r_rdata <= r_mem[w_rd_word];
  end

  always_comb begin
    w_lane_byte = r_rdata[31:24];
    case (r_addr[1:0])
      2'd1:    w_lane_byte = r_rdata[23:16];
      2'd2:    w_lane_byte = r_rdata[15:8];
      2'd3:    w_lane_byte = r_rdata[7:0];
      default: w_lane_byte = r_rdata[31:24];
    endcase
  end

  always_comb begin
    w_out_byte = 8'h00;
    case (r_state)
      S_READ:   w_out_byte = w_lane_byte;
      S_STATUS: w_out_byte = {6'b0, w_wel, 1'b0};
      S_ID: begin
        case (r_byte_cnt)
          2'd0:    w_out_byte = JEDEC_ID[23:16];
          2'd1:    w_out_byte = JEDEC_ID[15:8];
          2'd2:    w_out_byte = JEDEC_ID[7:0];
          default: w_out_byte = 8'h00;
        endcase
      end
      default:  w_out_byte = 8'h00;
    endcase
  end

`ifdef SFT_PROGRAM_EN
  // Pending latch action applied at the next cs_n high: 01 set, 10 clear.
  logic [1:0]  r_wel_cmd;
  logic        r_wel;
  logic        w_prog_we;
  logic [31:0] w_prog_data;

  assign w_wel     = r_wel;
  assign w_prog_we = (r_state == S_PROG) && !cs_n && w_rise &&
                     (r_bit_cnt[2:0] == 3'd7) && !sft_reset_i;

  // r_rdata holds the addressed word: r_addr is stable for the whole byte.
  always_comb begin
    w_prog_data = r_rdata;
    case (r_addr[1:0])
      2'd0:    w_prog_data[31:24] = r_rdata[31:24] & w_byte_in;
      2'd1:    w_prog_data[23:16] = r_rdata[23:16] & w_byte_in;
      2'd2:    w_prog_data[15:8]  = r_rdata[15:8]  & w_byte_in;
      default: w_prog_data[7:0]   = r_rdata[7:0]   & w_byte_in;
    endcase
  end

  always_ff @(posedge sft_clock_i) begin
    if (sft_reset_i) begin
      r_wel <= 1'b0;
    end else if (cs_n && r_wel_cmd == 2'b01) begin
      r_wel <= 1'b1;
    end else if (cs_n && r_wel_cmd == 2'b10) begin
      r_wel <= 1'b0;
    end
  end
`else
  assign w_wel = 1'b0;
`endif

  // Backdoor write comes last so it wins over a program write to the same word.
  always_ff @(posedge sft_clock_i) begin
`ifdef SFT_PROGRAM_EN
    if (w_prog_we) begin
      r_mem[r_addr[AW+1:2]] <= w_prog_data;
    end
`endif
    if (init_wen) begin
      r_mem[init_addr] <= init_data;
    end
  end

  always_ff @(posedge sft_clock_i) begin
    if (sft_reset_i) begin
      r_sck_prev <= 1'b1;
      r_cs_prev  <= 1'b0;   // a select already low at reset is not a fresh fall
      r_state    <= S_IDLE;
      r_bit_cnt  <= 5'd0;
      r_byte_cnt <= 2'd0;
      r_shift_in <= 7'd0;
      r_tx       <= 8'd0;
      r_addr     <= 24'd0;
      r_is_prog  <= 1'b0;
      r_miso     <= 1'b0;
`ifdef SFT_PROGRAM_EN
      r_wel_cmd  <= 2'b00;
`endif
    end else begin
      r_sck_prev <= sck;
      r_cs_prev  <= cs_n;
      if (cs_n) begin
        r_state    <= S_IDLE;
        r_bit_cnt  <= 5'd0;
        r_byte_cnt <= 2'd0;
        r_miso     <= 1'b0;
`ifdef SFT_PROGRAM_EN
        r_wel_cmd  <= 2'b00;
`endif
      end else if (w_cs_fall) begin
        r_state    <= S_OPCODE;
        r_bit_cnt  <= 5'd0;
        r_byte_cnt <= 2'd0;
        r_miso     <= 1'b0;
      end else begin
        case (r_state)
          S_OPCODE: if (w_rise) begin
            r_shift_in <= w_byte_in[6:0];
            r_bit_cnt  <= r_bit_cnt + 5'd1;
            if (r_bit_cnt == 5'd7) begin
              r_bit_cnt <= 5'd0;
              case (w_byte_in)
                8'h03: begin r_state <= S_ADDR; r_is_prog <= 1'b0; end
                8'h05: r_state <= S_STATUS;
                8'h9F: r_state <= S_ID;
`ifdef SFT_PROGRAM_EN
                8'h06: begin r_state <= S_IGNORE; r_wel_cmd <= 2'b01; end
                8'h04: begin r_state <= S_IGNORE; r_wel_cmd <= 2'b10; end
                8'h02: begin
                  if (r_wel) begin
                    r_state   <= S_ADDR;
                    r_is_prog <= 1'b1;
                    r_wel_cmd <= 2'b10;
                  end else begin
                    r_state <= S_IGNORE;
                  end
                end
`endif
                default: r_state <= S_IGNORE;
              endcase
            end
          end
          S_ADDR: if (w_rise) begin
            r_addr    <= w_addr_in;
            r_bit_cnt <= r_bit_cnt + 5'd1;
            if (r_bit_cnt == 5'd23) begin
              r_bit_cnt <= 5'd0;
              r_state   <= r_is_prog ? S_PROG : S_READ;
            end
          end
          S_READ, S_STATUS, S_ID: if (w_fall) begin
            r_bit_cnt <= {2'b00, r_bit_cnt[2:0] + 3'd1};
            if (r_bit_cnt[2:0] == 3'd0) begin
              r_miso <= w_out_byte[7];
              r_tx   <= {w_out_byte[6:0], 1'b0};
              // Advance now so the next word fetch has a whole byte time.
              if (r_state == S_READ) r_addr <= r_addr + 24'd1;
              if (r_state == S_ID && r_byte_cnt != 2'd3) r_byte_cnt <= r_byte_cnt + 2'd1;
            end else begin
              r_miso <= r_tx[7];
              r_tx   <= {r_tx[6:0], 1'b0};
            end
          end
          S_PROG: if (w_rise) begin
            r_shift_in <= w_byte_in[6:0];
            r_bit_cnt  <= {2'b00, r_bit_cnt[2:0] + 3'd1};
            if (r_bit_cnt[2:0] == 3'd7) begin
              r_addr <= {r_addr[23:8], r_addr[7:0] + 8'd1};
            end
          end
          S_IGNORE: begin
`ifdef SFT_PROGRAM_EN
            // WREN/WRDI only count when exactly eight bits were clocked.
            if (w_rise) r_wel_cmd <= 2'b00;
`endif
          end
          default: ;
        endcase
      end
    end
  end

  assign miso  = r_miso;
  assign wel_o = w_wel;

endmodule

// File: tb/tb_spi_flash_target.sv
// tb/tb_spi_flash_target.sv - randomized self-checking bench for spi_flash_target
module tb_spi_flash_target;

  localparam int MW = 64;
  localparam int AW = $clog2(MW);

  logic          clk = 1'b0;
  logic          rst;
  logic          sck;
  logic          mosi;
  logic          cs_n;
  logic          miso;
  logic          init_wen;
  logic [AW-1:0] init_addr;
  logic [31:0]   init_data;
  logic          wel;

  int checks   = 0;
  int failures = 0;

  logic [31:0] model_mem [MW];
  logic        model_wel;

  always #5 clk = ~clk;

  spi_flash_target #(.MEM_WORDS(MW), .JEDEC_ID(24'hEF4016)) dut (
    .sft_clock_i (clk),
    .sft_reset_i (rst),
    .sck         (sck),
    .mosi        (mosi),
    .cs_n        (cs_n),
    .miso        (miso),
    .init_wen    (init_wen),
    .init_addr   (init_addr),
    .init_data   (init_data),
    .wel_o       (wel)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  // Flash byte at byte address a: big-endian within each word, aliased.
  function automatic logic [7:0] model_byte(input logic [23:0] a);
    logic [31:0] w;
    int          idx;
    idx = int'(a) % (4 * MW) / 4;
    w   = model_mem[idx];
    return 8'(w >> (8 * (3 - int'(a) % 4)));
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic spi_bit(input logic b, input bit fast, output logic r);
    int lo, hi;
    lo = fast ? 1 : int'($urandom_range(1, 3));
    hi = fast ? 1 : int'($urandom_range(1, 3));
    sck  = 1'b0;
    mosi = b;
    tick(lo);
    r   = miso;
    sck = 1'b1;
    tick(hi);
  endtask

  task automatic spi_byte(input logic [7:0] tx, input bit fast, output logic [7:0] rx);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      spi_bit(tx[i], fast, r);
      rx[i] = r;
    end
  endtask

  task automatic cs_begin();
    cs_n = 1'b0;
    tick(1 + int'($urandom_range(0, 1)));
  endtask

  task automatic cs_end();
    cs_n = 1'b1;
    sck  = 1'b1;
    mosi = 1'b0;
    tick(3);
  endtask

  task automatic backdoor(input int w, input logic [31:0] d);
    init_wen  = 1'b1;
    init_addr = AW'(w);
    init_data = d;
    tick(1);
    init_wen  = 1'b0;
    model_mem[w] = d;
  endtask

  task automatic send_hdr(input logic [7:0] op, input logic [23:0] a, input bit fast);
    logic [7:0] rx;
    spi_byte(op, fast, rx);
    spi_byte(a[23:16], fast, rx);
    spi_byte(a[15:8], fast, rx);
    spi_byte(a[7:0], fast, rx);
  endtask

  task automatic do_read(input string tag, input logic [23:0] a, input int n,
                         input bit fast, output logic [31:0] last4);
    logic [7:0] rx;
    last4 = 32'd0;
    cs_begin();
    send_hdr(8'h03, a, fast);
    for (int k = 0; k < n; k++) begin
      spi_byte(8'h00, fast, rx);
      check(tag, {24'd0, rx}, {24'd0, model_byte(a + 24'(k))});
      last4 = {last4[23:0], rx};
    end
    cs_end();
  endtask

  task automatic do_status(input string tag);
    logic [7:0] rx;
    cs_begin();
    spi_byte(8'h05, 1'b0, rx);
    for (int k = 0; k < 2; k++) begin
      spi_byte(8'h00, 1'b0, rx);
      check(tag, {24'd0, rx}, {30'd0, model_wel, 1'b0});
    end
    cs_end();
  endtask

  task automatic simple_cmd(input logic [7:0] op);
    logic [7:0] rx;
    cs_begin();
    spi_byte(op, 1'b0, rx);
    cs_end();
`ifdef SFT_PROGRAM_EN
    if (op == 8'h06) model_wel = 1'b1;
    if (op == 8'h04) model_wel = 1'b0;
`endif
  endtask

  // Page program of n bytes taken MSB-first from dw.
  task automatic do_prog(input logic [23:0] a, input logic [31:0] dw, input int n);
    logic [7:0]  rx;
    logic [7:0]  d;
    logic [31:0] mask;
    logic [23:0] pa;
    bit          ok;
    int          idx;
    cs_begin();
    send_hdr(8'h02, a, 1'b0);
    for (int k = 0; k < n; k++) begin
      d = 8'(dw >> (8 * (3 - k)));
      spi_byte(d, 1'b0, rx);
    end
    cs_end();
    ok = model_wel;
    model_wel = 1'b0;
    pa = a;
    for (int k = 0; k < n; k++) begin
      d = 8'(dw >> (8 * (3 - k)));
      if (ok) begin
        idx  = int'(pa) % (4 * MW) / 4;
        mask = {24'd0, ~d} << (8 * (3 - int'(pa) % 4));
        model_mem[idx] = model_mem[idx] & ~mask;
      end
      pa = {pa[23:8], pa[7:0] + 8'd1};
    end
  endtask

  initial begin
    logic [31:0] got;
    logic [7:0]  rx;
    logic        rb;

    for (int i = 0; i < MW; i++) model_mem[i] = 32'hFFFF_FFFF;
    model_wel = 1'b0;
    rst = 1'b1; sck = 1'b1; mosi = 1'b0; cs_n = 1'b1;
    init_wen = 1'b0; init_addr = '0; init_data = '0;
    tick(3);
    check("reset_miso", {31'd0, miso}, 32'd0);
    check("reset_wel", {31'd0, wel}, 32'd0);
    rst = 1'b0;
    tick(2);

    do_read("erased", 24'h000020, 2, 1'b0, got);

    backdoor(4, 32'h1234_5678);
    backdoor(5, 32'h9ABC_DEF0);
    do_read("read_fast", 24'h000010, 4, 1'b1, got);
    check("read_word4", got, 32'h1234_5678);

    do_read("read_cross", 24'h000013, 2, 1'b0, got);
    check("read_cross_val", got, 32'h0000_789A);

    backdoor(0, 32'hA1B2_C3D4);
    backdoor(MW - 1, 32'h0102_0355);
    do_read("read_wrap", 24'(4 * MW - 1), 2, 1'b0, got);
    check("read_wrap_val", got, 32'h0000_55A1);

    cs_begin();
    spi_byte(8'h9F, 1'b0, rx);
    got = 32'd0;
    for (int k = 0; k < 4; k++) begin
      spi_byte(8'h00, 1'b0, rx);
      got = {got[23:0], rx};
    end
    cs_end();
    check("jedec_id", got, 32'hEF40_1600);

    do_status("status_idle");

    cs_begin();
    spi_byte(8'h03, 1'b0, rx);
    spi_byte(8'h00, 1'b0, rx);
    for (int k = 0; k < 4; k++) spi_bit(1'b1, 1'b0, rb);
    cs_end();
    do_read("after_abort", 24'h000010, 4, 1'b0, got);
    check("after_abort_val", got, 32'h1234_5678);

    cs_begin();
    spi_byte(8'hAB, 1'b0, rx);
    spi_byte(8'hFF, 1'b0, rx);
    cs_end();
    check("unknown_op_miso", {24'd0, rx}, 32'd0);

    simple_cmd(8'h06);
    check("wren_wel", {31'd0, wel}, {31'd0, model_wel});
    do_status("status_wren");
    do_prog(24'h000040, 32'h0F00_0000, 1);
    check("prog_wel_cleared", {31'd0, wel}, {31'd0, model_wel});
    do_read("prog_read", 24'h000040, 4, 1'b0, got);
`ifdef SFT_PROGRAM_EN
    check("prog_word", got, 32'h0FFF_FFFF);
`else
    check("prog_word", got, 32'hFFFF_FFFF);
`endif
    do_status("status_after_prog");
    do_prog(24'h000040, 32'h0000_0000, 1);
    do_read("prog_no_wel", 24'h000040, 4, 1'b0, got);

    simple_cmd(8'h06);
    do_prog(24'h0001FE, 32'hF0F0_3C3C, 4);
    do_read("prog_page_lo", 24'h000100, 4, 1'b0, got);
    do_read("prog_page_hi", 24'h0001FC, 4, 1'b0, got);

    simple_cmd(8'h06);
    simple_cmd(8'h04);
    check("wrdi_wel", {31'd0, wel}, {31'd0, model_wel});

    cs_begin();
    spi_byte(8'h06, 1'b0, rx);
    spi_bit(1'b0, 1'b0, rb);
    cs_end();
    check("wren_9bits_wel", {31'd0, wel}, {31'd0, model_wel});

    simple_cmd(8'h06);
    cs_begin();
    send_hdr(8'h03, 24'h000010, 1'b0);
    spi_byte(8'h00, 1'b0, rx);
    check("rst_pre_byte", {24'd0, rx}, 32'h0000_0012);
    for (int k = 0; k < 3; k++) spi_bit(1'b0, 1'b0, rb);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    model_wel = 1'b0;
    check("rst_mid_miso", {31'd0, miso}, 32'd0);
    check("rst_mid_wel", {31'd0, wel}, 32'd0);
    spi_byte(8'h9F, 1'b0, rx);
    check("rst_ignored_bits", {24'd0, rx}, 32'd0);
    cs_end();
    do_read("rst_reread", 24'h000010, 4, 1'b0, got);
    check("rst_reread_val", got, 32'h1234_5678);

    for (int it = 0; it < 24; it++) begin
      if ($urandom_range(0, 1) == 1) backdoor(int'($urandom_range(0, MW - 1)), $urandom);
      do_read("rand_read", 24'($urandom), int'($urandom_range(1, 6)),
              1'($urandom_range(0, 1)), got);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
